// File: rtl/image_feeder_if.sv
// image_feeder_if: memory read port plus classifier stream/result signals between the feeder and its peers.
interface image_feeder_if;
    logic [23:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        start_main;
    logic [1:0]  train_test_classify;
    logic [7:0]  test_label;
    logic [31:0] image_in;
    logic        valid_image;
    logic        ready;
    logic        valid_all;
    logic [7:0]  image_label;

    modport master (
        output mem_addr, start_main, train_test_classify, test_label, image_in, valid_image,
        input  mem_rdata, ready, valid_all, image_label
    );

    modport slave (
        input  mem_addr, start_main, train_test_classify, test_label, image_in, valid_image,
        output mem_rdata, ready, valid_all, image_label
    );
endinterface

// File: rtl/image_feeder.sv
// image_feeder: streams labelled images from word memory to a classifier, counting results and timeouts.
module image_feeder #(
    parameter int IM_WID  = 28,
    parameter int IM_HEI  = 28,
    parameter int WPI     = 196,
    parameter int TIMEOUT = 1000000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          go,
    input  logic [15:0]   num_images,
    input  logic [1:0]    mode,
    output logic          busy,
    output logic          done,
    output logic          timeout_err,
    output logic [15:0]   img_count,
    output logic [15:0]   correct_count,
    image_feeder_if.master bus
);
    localparam int IW = $clog2(WPI + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    if ((IM_WID * IM_HEI + 3) / 4 != WPI) begin : g_geom_check
        $error("image_feeder: WPI does not match IM_WID*IM_HEI/4");
    end

    typedef enum logic [3:0] {
        IDLE, LBL_RD, LBL_CAP, START, PIX_RD, PIX_CAP, SEND, WAIT_RES, NEXT, FIN
    } state_t;

    state_t        state, nxt;
    logic [23:0]   base;
    logic [IW-1:0] widx;
    logic [TW-1:0] wcnt;
    logic [15:0]   num_r;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:     nxt = go ? (num_images == 16'd0 ? FIN : LBL_RD) : IDLE;
            LBL_RD:   nxt = LBL_CAP;
            LBL_CAP:  nxt = START;
            START:    nxt = PIX_RD;
            PIX_RD:   nxt = PIX_CAP;
            PIX_CAP:  nxt = SEND;
            SEND:     nxt = bus.ready ? (widx == IW'(WPI - 1) ? WAIT_RES : PIX_RD) : SEND;
            WAIT_RES: nxt = bus.valid_all ? NEXT : (wcnt == TW'(TIMEOUT - 1) ? FIN : WAIT_RES);
            NEXT:     nxt = img_count < num_r ? LBL_RD : FIN;
            FIN:      nxt = IDLE;
            default:  nxt = IDLE;
        endcase
    end

    always_comb begin
        busy           = state != IDLE;
        done           = state == FIN;
        bus.start_main = state == START;
        bus.mem_addr   = state == LBL_RD ? base + 24'(WPI) :
                         state == PIX_RD ? base + 24'(widx) : 24'd0;
    end

    // Label and pixel captures land one cycle after their address, matching the memory latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            base                    <= '0;
            widx                    <= '0;
            wcnt                    <= '0;
            num_r                   <= '0;
            bus.train_test_classify <= '0;
            bus.test_label          <= '0;
            bus.image_in            <= '0;
            bus.valid_image         <= 1'b0;
            timeout_err             <= 1'b0;
            img_count               <= '0;
            correct_count           <= '0;
        end else begin
            case (state)
                IDLE: if (go) begin
                    num_r                   <= num_images;
                    bus.train_test_classify <= mode;
                    base                    <= '0;
                    timeout_err             <= 1'b0;
                    img_count               <= '0;
                    correct_count           <= '0;
                end
                LBL_CAP: bus.test_label <= bus.mem_rdata[7:0];
                START:   widx <= '0;
                PIX_CAP: begin
                    bus.image_in    <= bus.mem_rdata;
                    bus.valid_image <= 1'b1;
                end
                SEND: if (bus.ready) begin
                    bus.valid_image <= 1'b0;
                    widx            <= widx + 1'b1;
                    wcnt            <= '0;
                end
                WAIT_RES: begin
                    if (bus.valid_all) begin
                        img_count <= &img_count ? img_count : img_count + 16'd1;
                        if (bus.train_test_classify == 2'b01 && bus.image_label == bus.test_label && !(&correct_count))
                            correct_count <= correct_count + 16'd1;
                    end else if (wcnt == TW'(TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                NEXT:    base <= base + 24'(WPI + 1);
                default: ;
            endcase
        end
    end
endmodule
